// File: rtl/heap_sort_pkg.sv
// Shared types and helpers for the heap sorter stimulus/response checker.
package heap_sort_pkg;

    typedef enum logic [2:0] {GEN, DRIVE, WAIT, CHECK, SUM, NEXT, DONE} state_t;

    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    // Widest packed vector elem() can address; N*W must not exceed it.
    localparam int unsigned VEC_MAX = 1024;

    function automatic logic [31:0] elem(input logic [VEC_MAX-1:0] vec,
                                         input int unsigned i,
                                         input int unsigned w);
        return 32'(vec >> (i * w)) & (32'hFFFF_FFFF >> (32 - w));
    endfunction

    // Wide enough that N elements of W bits can never overflow the sum.
    function automatic int unsigned csum_width(input int unsigned n, input int unsigned w);
        return w + $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/heap_sort_lfsr.sv
// 32-bit Galois LFSR; nxt_bits exposes the low bits of the value after the next shift.
module heap_sort_lfsr
    import heap_sort_pkg::*;
#(
    parameter logic [31:0] SEED  = 32'hACE1_2468,
    parameter int unsigned OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    output logic [OUT_W-1:0] nxt_bits
);

    logic [31:0] lfsr;
    logic [31:0] lfsr_nxt;

    always_comb begin
        lfsr_nxt = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_MASK : '0);
    end

    assign nxt_bits = lfsr_nxt[OUT_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      lfsr <= SEED;
        else if (adv) lfsr <= lfsr_nxt;
    end

endmodule

// File: rtl/heap_sort_check.sv
// Self-checking harness for the N-element heap sorter: LFSR stimulus, order and
// checksum checking of each response, with a per-vector timeout.
module heap_sort_check
    import heap_sort_pkg::*;
#(
    parameter int unsigned N          = 10,
    parameter int unsigned W          = 16,
    parameter int unsigned NUM_VEC    = 64,
    parameter int unsigned TIMEOUT    = 1024,
    parameter bit          DESCENDING = 1'b0,
    parameter logic [31:0] SEED       = 32'hACE1_2468
) (
    input  logic         system1000,
    input  logic         system1000_rst,
    output logic [N*W:0] dut_in,
    input  logic [N*W:0] dut_out,
    output logic         done,
    output logic         pass,
    output logic [15:0]  err_count,
    output logic [15:0]  vec_count
);

    localparam int unsigned CW = csum_width(N, W);
    localparam int unsigned IW = $clog2(N) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT) + 1;

    state_t          state, state_nxt;
    logic [IW-1:0]   idx;
    logic [TW-1:0]   wait_cnt;
    logic [N*W-1:0]  stim, stim_nxt, cap;
    logic [CW-1:0]   sum_in, sum_out;
    logic            fail;
    logic            adv;
    logic [W-1:0]    gen_elem, cur, prv;
    logic [31:0]     cur_full, prv_full;
    logic            last_idx, timeout_hit, last_vec, ord_bad;

    heap_sort_lfsr #(.SEED(SEED), .OUT_W(W)) u_lfsr (
        .clk      (system1000),
        .rst      (system1000_rst),
        .adv      (adv),
        .nxt_bits (gen_elem)
    );

    assign last_idx    = (idx == IW'(N - 1));
    assign timeout_hit = (wait_cnt == TW'(TIMEOUT - 1));
    assign last_vec    = ((17'(vec_count) + 17'd1) == 17'(NUM_VEC));

    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) state <= GEN;
        else                state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            GEN:     if (last_idx) state_nxt = DRIVE;
            DRIVE:   state_nxt = WAIT;
            WAIT:    if (dut_out[N*W]) state_nxt = CHECK;
                     else if (timeout_hit) state_nxt = NEXT;
            CHECK:   if (last_idx) state_nxt = SUM;
            SUM:     state_nxt = NEXT;
            NEXT:    state_nxt = last_vec ? DONE : GEN;
            DONE:    state_nxt = DONE;
            default: state_nxt = GEN;
        endcase
    end

    always_comb begin
        adv      = (state == GEN);
        stim_nxt = stim;
        for (int unsigned k = 0; k < N; k++) begin
            if (idx == IW'(k)) stim_nxt[k*W +: W] = gen_elem;
        end
        cur_full = elem(VEC_MAX'(cap), 32'(idx), W);
        prv_full = elem(VEC_MAX'(cap), 32'(idx) - 32'd1, W);
        cur      = cur_full[W-1:0];
        prv      = prv_full[W-1:0];
        ord_bad  = (idx != '0) && (DESCENDING ? (prv < cur) : (prv > cur));
    end

    // dut_in is loaded on the last GEN edge so its valid bit is high for exactly the DRIVE cycle.
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            dut_in    <= '0;
            stim      <= '0;
            cap       <= '0;
            idx       <= '0;
            wait_cnt  <= '0;
            sum_in    <= '0;
            sum_out   <= '0;
            fail      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            vec_count <= '0;
        end else begin
            case (state)
                GEN: begin
                    stim   <= stim_nxt;
                    sum_in <= sum_in + CW'(gen_elem);
                    idx    <= last_idx ? '0 : idx + 1'b1;
                    if (last_idx) dut_in <= {1'b1, stim_nxt};
                end
                DRIVE: begin
                    dut_in[N*W] <= 1'b0;
                    wait_cnt    <= '0;
                end
                WAIT: begin
                    if (dut_out[N*W])     cap      <= dut_out[N*W-1:0];
                    else if (timeout_hit) fail     <= 1'b1;
                    else                  wait_cnt <= wait_cnt + 1'b1;
                end
                CHECK: begin
                    sum_out <= sum_out + CW'(cur);
                    if (ord_bad) fail <= 1'b1;
                    idx <= last_idx ? '0 : idx + 1'b1;
                end
                SUM: begin
                    if (sum_out != sum_in) fail <= 1'b1;
                end
                NEXT: begin
                    if (fail && err_count != '1) err_count <= err_count + 1'b1;
                    vec_count <= vec_count + 1'b1;
                    fail      <= 1'b0;
                    sum_in    <= '0;
                    sum_out   <= '0;
                    if (last_vec) begin
                        done <= 1'b1;
                        pass <= !fail && (err_count == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_heap_sort_check.sv
// Runs six checker instances against behavioural sorter models (ideal, faulty,
// silent, descending) and a mid-run reset, comparing against hand-derived values.
module tb_heap_sort_check;

    localparam int unsigned NI = 6;
    localparam logic [31:0] SEED = 32'hACE1_2468;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [160:0] din    [NI];
    logic [160:0] pipe_a [NI];
    logic [160:0] pipe_b [NI];
    logic [160:0] pipe_c [NI];
    int           vcnt   [NI];
    logic [NI-1:0] done_v, pass_v;
    logic [15:0]  err_v  [NI];
    logic [15:0]  vec_v  [NI];

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // 0 ascending, 1 swap 0/1 on vector 2, 2 duplicate neighbour on vector 0, 3 silent, 4 descending
    function automatic int mode_of(input int k);
        case (k)
            1:       return 1;
            2:       return 2;
            3:       return 3;
            5:       return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [160:0] model_resp(input logic [160:0] d, input int mode, input int vidx);
        logic [15:0]  e [10];
        logic [15:0]  t;
        logic [159:0] o;
        if (mode == 3) return '0;
        for (int i = 0; i < 10; i++) e[i] = d[i*16 +: 16];
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < 9 - i; j++) begin
                if ((mode == 4) ? (e[j] < e[j+1]) : (e[j] > e[j+1])) begin
                    t = e[j]; e[j] = e[j+1]; e[j+1] = t;
                end
            end
        end
        if (mode == 1 && vidx == 2) begin
            t = e[0]; e[0] = e[1]; e[1] = t;
        end
        if (mode == 2 && vidx == 0) e[1] = e[0];
        for (int i = 0; i < 10; i++) o[i*16 +: 16] = e[i];
        return {1'b1, o};
    endfunction

    function automatic logic [159:0] first_vector();
        logic [31:0]  l;
        logic [159:0] v;
        l = SEED;
        for (int i = 0; i < 10; i++) begin
            l = (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
            v[i*16 +: 16] = l[15:0];
        end
        return v;
    endfunction

    // Three-deep pipeline: response is sampled on the third edge after the DRIVE edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NI; k++) begin
                pipe_a[k] <= '0; pipe_b[k] <= '0; pipe_c[k] <= '0; vcnt[k] <= 0;
            end
        end else begin
            for (int k = 0; k < NI; k++) begin
                pipe_a[k] <= din[k][160] ? model_resp(din[k], mode_of(k), vcnt[k]) : '0;
                if (din[k][160]) vcnt[k] <= vcnt[k] + 1;
                pipe_b[k] <= pipe_a[k];
                pipe_c[k] <= pipe_b[k];
            end
        end
    end

    heap_sort_check #(.NUM_VEC(4)) d0 (
        .system1000(clk), .system1000_rst(rst), .dut_in(din[0]), .dut_out(pipe_c[0]),
        .done(done_v[0]), .pass(pass_v[0]), .err_count(err_v[0]), .vec_count(vec_v[0]));
    heap_sort_check #(.NUM_VEC(4)) d1 (
        .system1000(clk), .system1000_rst(rst), .dut_in(din[1]), .dut_out(pipe_c[1]),
        .done(done_v[1]), .pass(pass_v[1]), .err_count(err_v[1]), .vec_count(vec_v[1]));
    heap_sort_check #(.NUM_VEC(4)) d2 (
        .system1000(clk), .system1000_rst(rst), .dut_in(din[2]), .dut_out(pipe_c[2]),
        .done(done_v[2]), .pass(pass_v[2]), .err_count(err_v[2]), .vec_count(vec_v[2]));
    heap_sort_check #(.NUM_VEC(2), .TIMEOUT(8)) d3 (
        .system1000(clk), .system1000_rst(rst), .dut_in(din[3]), .dut_out(pipe_c[3]),
        .done(done_v[3]), .pass(pass_v[3]), .err_count(err_v[3]), .vec_count(vec_v[3]));
    heap_sort_check #(.NUM_VEC(4), .DESCENDING(1'b1)) d4 (
        .system1000(clk), .system1000_rst(rst), .dut_in(din[4]), .dut_out(pipe_c[4]),
        .done(done_v[4]), .pass(pass_v[4]), .err_count(err_v[4]), .vec_count(vec_v[4]));
    heap_sort_check #(.NUM_VEC(4), .DESCENDING(1'b1)) d5 (
        .system1000(clk), .system1000_rst(rst), .dut_in(din[5]), .dut_out(pipe_c[5]),
        .done(done_v[5]), .pass(pass_v[5]), .err_count(err_v[5]), .vec_count(vec_v[5]));

    initial begin
        logic [159:0] vec_run1, vec_run2;
        bit           got1, got2;
        int           first0, first3;

        repeat (3) @(posedge clk);
        #1;
        check("rst_dut_in", 192'(din[0]), 192'd0);
        check("rst_done",   192'(done_v[0]), 192'd0);
        check("rst_pass",   192'(pass_v[0]), 192'd0);
        check("rst_err",    192'(err_v[0]), 192'd0);
        check("rst_vec",    192'(vec_v[0]), 192'd0);

        @(negedge clk);
        rst = 1'b0;
        got1 = 0; first0 = 0; first3 = 0; vec_run1 = '0;
        for (int c = 1; c <= 120; c++) begin
            @(posedge clk);
            #1;
            if (!got1 && din[0][160]) begin
                vec_run1 = din[0][159:0];
                got1 = 1;
            end
            if (done_v[0] && first0 == 0) first0 = c;
            if (done_v[3] && first3 == 0) first3 = c;
        end

        check("drive_seen",  192'(got1), 192'd1);
        check("stim_e0",     192'(vec_run1[15:0]),  192'h9234);
        check("stim_e1",     192'(vec_run1[31:16]), 192'h491A);
        check("stim_e2",     192'(vec_run1[47:32]), 192'h248D);
        check("stim_e3",     192'(vec_run1[63:48]), 192'h1245);
        check("stim_vec0",   192'(vec_run1), 192'(first_vector()));

        check("ideal_done_cycle", 192'(first0), 192'd104);
        check("ideal_pass",  192'(pass_v[0]), 192'd1);
        check("ideal_err",   192'(err_v[0]),  192'd0);
        check("ideal_vec",   192'(vec_v[0]),  192'd4);

        check("swap_err",    192'(err_v[1]),  192'd1);
        check("swap_pass",   192'(pass_v[1]), 192'd0);
        check("swap_done",   192'(done_v[1]), 192'd1);

        check("dup_err",     192'(err_v[2]),  192'd1);
        check("dup_pass",    192'(pass_v[2]), 192'd0);

        check("tmo_done_cycle", 192'(first3), 192'd40);
        check("tmo_err",     192'(err_v[3]),  192'd2);
        check("tmo_vec",     192'(vec_v[3]),  192'd2);
        check("tmo_pass",    192'(pass_v[3]), 192'd0);

        check("desc_asc_err",   192'(err_v[4]),  192'd4);
        check("desc_asc_pass",  192'(pass_v[4]), 192'd0);
        check("desc_desc_err",  192'(err_v[5]),  192'd0);
        check("desc_desc_pass", 192'(pass_v[5]), 192'd1);

        rst = 1'b1;
        #1;
        check("async_rst_done", 192'(done_v[0]), 192'd0);
        check("async_rst_pass", 192'(pass_v[0]), 192'd0);
        @(negedge clk);
        rst = 1'b0;

        // Edge 43 after release falls inside CHECK of vector 1.
        repeat (43) @(posedge clk);
        #1;
        check("mid_vec_before", 192'(vec_v[0]), 192'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_dut_in", 192'(din[0]), 192'd0);
        check("mid_rst_vec",    192'(vec_v[0]), 192'd0);
        @(negedge clk);
        rst = 1'b0;

        got2 = 0; vec_run2 = '0;
        for (int c = 0; c < 30 && !got2; c++) begin
            @(posedge clk);
            #1;
            if (din[0][160]) begin
                vec_run2 = din[0][159:0];
                got2 = 1;
            end
        end
        check("rerun_drive_seen", 192'(got2), 192'd1);
        check("rerun_stim_vec0",  192'(vec_run2), 192'(vec_run1));

        for (int c = 0; c < 150 && !done_v[0]; c++) begin
            @(posedge clk);
            #1;
        end
        check("rerun_done", 192'(done_v[0]), 192'd1);
        check("rerun_pass", 192'(pass_v[0]), 192'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/heap_sort_check.md
# heap_sort_check

Synthesizable, self-checking stimulus/response harness for the N-element heap sorter. It generates pseudo-random vectors from an LFSR and drives one vector at a time into the sorter. It then checks each returned vector for ordering and checksum, and reports `done`/`pass`. It replaces the fixed-width, fixed-stimulus, non-checking testbench. It is generalised in element count, element width, vector count and sort direction, and adds a timeout.

## Interface
- `N`, 10: elements per vector, ≥2.
- `W`, 16: element width, 1..32.
- `NUM_VEC`, 64: vectors to run, ≥1.
- `TIMEOUT`, 1024: max cycles to wait for a sorter response.
- `DESCENDING`, 0: 0 checks non-decreasing order, 1 checks non-increasing order.
- `SEED`, 32'hACE1_2468: initial LFSR state, nonzero.
- `system1000` in 1: the single clock; everything is rising-edge.
- `system1000_rst` in 1: reset, asynchronous and active-high.
- `dut_in` out N*W+1: to the sorter. Bit N*W is valid; element i occupies bits [i*W +: W].
- `dut_out` in N*W+1: from the sorter, same packing.
- `done` out 1: sticky; asserts once all vectors are finished.
- `pass` out 1: equals `done` AND `err_count`==0.
- `err_count` out 16: failing vectors; saturates at 16'hFFFF.
- `vec_count` out 16: vectors completed.

## Operation
- States: GEN, DRIVE, WAIT, CHECK, SUM, NEXT, DONE.
- Reset values: state GEN, LFSR=`SEED`, `dut_in`=0, `done`=0, `pass`=0, `err_count`=0, `vec_count`=0, all counters 0.
- LFSR: 32-bit Galois, mask 32'h8020_0003, shifted once per GEN cycle.
  - The element is LFSR[W-1:0] after the shift.
- GEN (N cycles): store element i into the stimulus register and add it to the input checksum.
  - Checksum width is W+$clog2(N)+1 and never overflows.
- DRIVE (1 cycle): `dut_in` = {1, stimulus}. Outside this cycle, `dut_in`[N*W] is 0 and the data bits hold the last stimulus.
- WAIT: the wait counter starts at 0.
  - If `dut_out`[N*W]=1, capture the data and go to CHECK.
  - Else if the counter reaches TIMEOUT-1, mark the vector failed and go to NEXT.
  - A valid pulse during GEN/CHECK/SUM/NEXT is ignored; it raises no error.
- CHECK (N cycles, index i=0..N-1, one element per cycle):
  - Add element i to the output checksum.
  - For i≥1, compare element i-1 against element i as unsigned values, using the order selected by DESCENDING.
  - A violation sets the per-vector fail flag.
- SUM (1 cycle): an output checksum ≠ input checksum sets the fail flag.
- NEXT (1 cycle):
  - If failed, `err_count`+=1 (saturating).
  - `vec_count`+=1, then clear the fail flag and both checksums.
  - If `vec_count`+1 == NUM_VEC, go to DONE; otherwise go to GEN.
  - The LFSR continues and is not reseeded.
- DONE: terminal. `done`=1 and `pass` updates in the same cycle. It leaves only on reset.
- A failure counts at most once per vector.
- Reset mid-operation: everything returns to reset values immediately (asynchronous). A new run starts from SEED on the first clock after deassertion.

## Timing
- Per vector: N (GEN) + 1 (DRIVE) + L (sorter latency, counted from the DRIVE edge to the valid-sample edge) + N (CHECK) + 1 (SUM) + 1 (NEXT) cycles.
- On timeout, L = TIMEOUT.
- L=0 is legal: a valid returned combinationally in the DRIVE cycle is not seen. The earliest capture is the first WAIT cycle.
- `done` and `pass` register on the edge leaving the last NEXT.
- `err_count` and `vec_count` update on the NEXT edge.
- `dut_in` is driven from flops, with no combinational path from `dut_out`.

## Structure
- Shared package `heap_sort_pkg` holds:
  - the state enum;
  - the LFSR mask constant;
  - a function `elem(vec, i)` for element extraction;
  - the checksum-width function.
- One sub-module, `heap_sort_lfsr`: 32-bit Galois LFSR with an `adv` enable and a SEED parameter.
- The FSM, counters and checker stay in `heap_sort_check`.

## Test plan
- Ideal sorter model (N=10, W=16, L=3, DESCENDING=0, NUM_VEC=4) -> `done` rises after 4×(10+1+3+10+1+1)=104 cycles, `pass`=1, `err_count`=0, `vec_count`=4.
- Model swaps elements 0 and 1 on vector 2 only -> `err_count`=1 (ordering fail, counted once), `pass`=0.
- Model replaces one element with a copy of its neighbour, so order is kept but the sum changes -> the SUM check fails, `err_count`=1.
- Model never asserts valid, TIMEOUT=8, NUM_VEC=2 -> each vector ends after 8 WAIT cycles, `err_count`=2, `done`=1.
- DESCENDING=1 with an ascending model -> every vector fails (barring an all-equal vector), `err_count`=NUM_VEC; with a descending model -> `pass`=1.
- Reset asserted during CHECK of vector 1 and released -> outputs go to 0 at once; the rerun reproduces the identical first stimulus (starting from SEED).
